// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register offsets, access encodings and FSM states.
package clint_pkg;

    localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h0200_0000;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int CTRL_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } clint_state_e;

endpackage

// File: rtl/clint_lane_merge.sv
// rtl/clint_lane_merge.sv - byte-lane write merge and read extract/extend.
module clint_lane_merge
    import clint_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // A halfword on an odd lane degrades to a single byte at that lane.
    always_comb begin
        o_merged = i_word;
        if (i_size == SIZE_BYTE || (i_size == SIZE_HALF && i_lane[0])) begin
            case (i_lane)
                2'd0:    o_merged[7:0]   = i_wdata[7:0];
                2'd1:    o_merged[15:8]  = i_wdata[7:0];
                2'd2:    o_merged[23:16] = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end else if (i_size == SIZE_HALF) begin
            if (i_lane[1]) begin
                o_merged[31:16] = i_wdata[15:0];
            end else begin
                o_merged[15:0] = i_wdata[15:0];
            end
        end else begin
            o_merged = i_wdata;
        end
    end

    always_comb begin
        w_shifted = i_word >> {i_lane, 3'b000};
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/clint_responder.sv
// rtl/clint_responder.sv - CLINT data-bus responder driving mtimecmp/mip updates.
// Define CLINT_ACCESS_FAULT_EN to add resp_err for unmapped offsets and mtime writes.
module clint_responder
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE     = CLINT_BASE_DEFAULT,
    parameter int          MTIP_BIT = 7,
    parameter int          MSIP_BIT = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    input  logic [2:0]   req_ctrl,
    input  logic         req_we,
    input  logic [31:0]  req_wdata,
    input  logic [63:0]  mtime,
    input  logic [63:0]  mtimecmp,
    input  logic [31:0]  mip_in,
    output logic         busy,
    output logic         resp_valid,
    output logic [127:0] rdata,
    output logic [63:0]  wmtimecmp,
    output logic         clint_we,
    output logic [31:0]  wmip,
`ifdef CLINT_ACCESS_FAULT_EN
    output logic         resp_err,
`endif
    output logic         plic_we
);

    clint_state_e r_state;
    clint_state_e w_next;

    logic [15:0] r_addr;
    logic [2:0]  r_ctrl;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_msip;
    logic [1:0]  r_mip_sent;
    logic        r_clint_we;
    logic [63:0] r_wmtimecmp;
    logic        r_plic_we;
    logic [31:0] r_wmip;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_in_access;
    logic [15:0] w_off;
    logic        w_hit_msip;
    logic        w_hit_lo;
    logic        w_hit_hi;
    logic [31:0] w_cur_word;
    logic [31:0] w_merged;
    logic [31:0] w_extract;
    logic        w_msip_next;
    logic [1:0]  w_cand;
    logic [31:0] w_mip_new;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && (req_addr[31:16] == BASE[31:16]);
    assign w_in_access = (r_state == ST_ACCESS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            ST_ACCESS: busy       = 1'b1;
            ST_RESP:   resp_valid = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        w_off      = {r_addr[15:2], 2'b00};
        w_hit_msip = (w_off == OFF_MSIP);
        w_hit_lo   = (w_off == OFF_MTIMECMP_LO);
        w_hit_hi   = (w_off == OFF_MTIMECMP_HI);
        case (w_off)
            OFF_MSIP:        w_cur_word = {31'b0, r_msip};
            OFF_MTIMECMP_LO: w_cur_word = mtimecmp[31:0];
            OFF_MTIMECMP_HI: w_cur_word = mtimecmp[63:32];
            OFF_MTIME_LO:    w_cur_word = mtime[31:0];
            OFF_MTIME_HI:    w_cur_word = mtime[63:32];
            default:         w_cur_word = 32'b0;
        endcase
    end

    clint_lane_merge u_lane (
        .i_word     (w_cur_word),
        .i_wdata    (r_wdata),
        .i_size     (r_ctrl[1:0]),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_ctrl[CTRL_UNSIGNED_BIT]),
        .o_merged   (w_merged),
        .o_rdata    (w_extract)
    );

    // The pending candidate sees an msip write already in ACCESS, so plic_we lands in RESP.
    assign w_msip_next = (w_in_access && r_we && w_hit_msip) ? w_merged[0] : r_msip;
    assign w_cand      = {(mtime >= mtimecmp), w_msip_next};

    always_comb begin
        w_mip_new           = mip_in;
        w_mip_new[MTIP_BIT] = w_cand[1];
        w_mip_new[MSIP_BIT] = w_cand[0];
    end

    // Strobes are registered out of ACCESS so a reset there suppresses them entirely.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr      <= '0;
            r_ctrl      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_msip      <= 1'b0;
            r_mip_sent  <= '0;
            r_clint_we  <= 1'b0;
            r_wmtimecmp <= '0;
            r_plic_we   <= 1'b0;
            r_wmip      <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr[15:0];
                r_ctrl  <= req_ctrl;
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            r_clint_we <= 1'b0;
            if (w_in_access) begin
                r_rdata <= r_we ? 32'b0 : w_extract;
                r_msip  <= w_msip_next;
                if (r_we && w_hit_lo) begin
                    r_clint_we  <= 1'b1;
                    r_wmtimecmp <= {mtimecmp[63:32], w_merged};
                end
                if (r_we && w_hit_hi) begin
                    r_clint_we  <= 1'b1;
                    r_wmtimecmp <= {w_merged, mtimecmp[31:0]};
                end
            end
            r_plic_we <= (w_cand != r_mip_sent);
            if (w_cand != r_mip_sent) begin
                r_mip_sent <= w_cand;
                r_wmip     <= w_mip_new;
            end
        end
    end

`ifdef CLINT_ACCESS_FAULT_EN
    logic r_err;
    logic w_fault;

    assign w_fault = !(w_hit_msip || w_hit_lo || w_hit_hi
                       || w_off == OFF_MTIME_LO || w_off == OFF_MTIME_HI)
                     || (r_we && (w_off == OFF_MTIME_LO || w_off == OFF_MTIME_HI));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_in_access) begin
            r_err <= w_fault;
        end
    end

    assign resp_err = (r_state == ST_RESP) && r_err;
`endif

    assign rdata     = {96'b0, r_rdata};
    assign wmtimecmp = r_wmtimecmp;
    assign clint_we  = r_clint_we;
    assign wmip      = r_wmip;
    assign plic_we   = r_plic_we;

endmodule
